// File: rtl/chaos_dds_if.sv
// Bus bundle for the chaotic DDS array: per-channel segment load inputs
// and the registered waveform / status outputs.
interface chaos_dds_if #(
  parameter int CH_NUM      = 4,
  parameter int PHASE_WIDTH = 32,
  parameter int DATA_WIDTH  = 8
);
  logic [CH_NUM-1:0]             ch_mode;
  logic [2*CH_NUM-1:0]           ch_wave;
  logic [CH_NUM-1:0]             chaotic_valid;
  logic [CH_NUM*PHASE_WIDTH-1:0] chaotic_x;
  logic [CH_NUM*PHASE_WIDTH-1:0] chaotic_y;
  logic [CH_NUM*PHASE_WIDTH-1:0] chaotic_z;
  logic                          chaotic_ctrl;
  logic [CH_NUM*DATA_WIDTH-1:0]  wave_out;
  logic [CH_NUM-1:0]             ch_active;
  logic [CH_NUM-1:0]             seg_done;

  modport master (
    output ch_mode, ch_wave, chaotic_valid, chaotic_x, chaotic_y, chaotic_z,
    input  chaotic_ctrl, wave_out, ch_active, seg_done
  );

  modport slave (
    input  ch_mode, ch_wave, chaotic_valid, chaotic_x, chaotic_y, chaotic_z,
    output chaotic_ctrl, wave_out, ch_active, seg_done
  );
endinterface

// File: rtl/chaos_dds_array.sv
// N-channel chaotic DDS core. A shared pacing timer requests new chaotic
// states; each channel runs its own phase accumulator over a segment loaded
// from its (x, y, z) triple and shapes the phase into saw/triangle/square.
//
// Channel state | meaning
// CH_IDLE       | no segment running; acc frozen, output at midscale
// CH_RUN        | accumulator advancing; truncated segments count wraps
module chaos_dds_array #(
  parameter int          CH_NUM           = 4,
  parameter int          PHASE_WIDTH      = 32,
  parameter int          PERIOD_NUM_WIDTH = 3,
  parameter int          FW_DEV_WIDTH     = 16,
  parameter int          DATA_WIDTH       = 8,
  parameter int unsigned FRQ_WORD         = 42_949_673,
  parameter int          CTRL             = 1000
) (
  input logic        clk,
  input logic        rst,
  chaos_dds_if.slave bus
);
  localparam int                     TMR_W    = $clog2(CTRL);
  localparam logic [TMR_W-1:0]       TMR_LAST = TMR_W'(CTRL - 1);
  localparam logic [PHASE_WIDTH-1:0] FW_BASE  = PHASE_WIDTH'(FRQ_WORD);
  localparam logic [DATA_WIDTH-1:0]  MIDSCALE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic {CH_IDLE = 1'b0, CH_RUN = 1'b1} ch_state_t;

  logic [TMR_W-1:0]            tmr;
  ch_state_t                   st       [CH_NUM];
  ch_state_t                   st_nxt   [CH_NUM];
  logic [PHASE_WIDTH-1:0]      acc      [CH_NUM];
  logic [PHASE_WIDTH-1:0]      acc_nxt  [CH_NUM];
  logic [PHASE_WIDTH-1:0]      fword    [CH_NUM];
  logic [PHASE_WIDTH-1:0]      fword_nxt[CH_NUM];
  logic [PERIOD_NUM_WIDTH-1:0] left     [CH_NUM];
  logic [PERIOD_NUM_WIDTH-1:0] left_nxt [CH_NUM];
  logic                        mode     [CH_NUM];
  logic                        mode_nxt [CH_NUM];
  logic [DATA_WIDTH-1:0]       wave_q   [CH_NUM];
  logic [DATA_WIDTH-1:0]       wave_nxt [CH_NUM];
  logic                        done_q   [CH_NUM];
  logic                        done_nxt [CH_NUM];
  logic [PHASE_WIDTH:0]        sum      [CH_NUM];
  logic [PERIOD_NUM_WIDTH-1:0] n_c      [CH_NUM];
  logic [DATA_WIDTH-1:0]       p        [CH_NUM];
  logic [1:0]                  wsel     [CH_NUM];

  // Free-running pacing timer, wraps after CTRL-1.
  always_ff @(posedge clk) begin
    if (rst || tmr == TMR_LAST) tmr <= '0;
    else                        tmr <= tmr + TMR_W'(1);
  end

  assign bus.chaotic_ctrl = (tmr == TMR_LAST);

  // Per-channel next state: load has priority over advance, so a valid on
  // the final wrap restarts the segment without a completion pulse.
  always_comb begin
    for (int c = 0; c < CH_NUM; c++) begin
      n_c[c]       = bus.chaotic_x[c*PHASE_WIDTH + PHASE_WIDTH - 1 -: PERIOD_NUM_WIDTH];
      sum[c]       = {1'b0, acc[c]} + {1'b0, fword[c]};
      st_nxt[c]    = st[c];
      acc_nxt[c]   = acc[c];
      fword_nxt[c] = fword[c];
      left_nxt[c]  = left[c];
      mode_nxt[c]  = mode[c];
      done_nxt[c]  = 1'b0;
      if (bus.chaotic_valid[c]) begin
        acc_nxt[c]   = bus.chaotic_y[c*PHASE_WIDTH +: PHASE_WIDTH];
        fword_nxt[c] = FW_BASE + PHASE_WIDTH'(bus.chaotic_z[c*PHASE_WIDTH + PHASE_WIDTH - 1 -: FW_DEV_WIDTH]);
        left_nxt[c]  = n_c[c];
        mode_nxt[c]  = bus.ch_mode[c];
        st_nxt[c]    = CH_RUN;
        // A truncated segment of zero periods never starts.
        if (bus.ch_mode[c] && n_c[c] == '0) begin
          st_nxt[c]  = CH_IDLE;
          acc_nxt[c] = '0;
        end
      end else if (st[c] == CH_RUN) begin
        acc_nxt[c] = sum[c][PHASE_WIDTH-1:0];
        if (mode[c] && sum[c][PHASE_WIDTH]) begin
          if (left[c] > PERIOD_NUM_WIDTH'(1)) begin
            left_nxt[c] = left[c] - PERIOD_NUM_WIDTH'(1);
          end else begin
            st_nxt[c]   = CH_IDLE;
            acc_nxt[c]  = '0;
            done_nxt[c] = 1'b1;
          end
        end
      end

      p[c]        = acc[c][PHASE_WIDTH-1 -: DATA_WIDTH];
      wsel[c]     = bus.ch_wave[2*c +: 2];
      wave_nxt[c] = p[c];
      if (st[c] == CH_IDLE) begin
        wave_nxt[c] = MIDSCALE;
      end else if (wsel[c] == 2'b01) begin
        wave_nxt[c] = p[c][DATA_WIDTH-1] ? ~{p[c][DATA_WIDTH-2:0], 1'b0}
                                         :  {p[c][DATA_WIDTH-2:0], 1'b0};
      end else if (wsel[c] == 2'b10) begin
        wave_nxt[c] = {DATA_WIDTH{p[c][DATA_WIDTH-1]}};
      end
    end
  end

  // Per-channel state registers; the waveform sample trails acc by one cycle.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CH_NUM; c++) begin
      if (rst) begin
        st[c]     <= CH_IDLE;
        acc[c]    <= '0;
        fword[c]  <= '0;
        left[c]   <= '0;
        mode[c]   <= 1'b0;
        wave_q[c] <= MIDSCALE;
        done_q[c] <= 1'b0;
      end else begin
        st[c]     <= st_nxt[c];
        acc[c]    <= acc_nxt[c];
        fword[c]  <= fword_nxt[c];
        left[c]   <= left_nxt[c];
        mode[c]   <= mode_nxt[c];
        wave_q[c] <= wave_nxt[c];
        done_q[c] <= done_nxt[c];
      end
    end
  end

  // Pack per-channel registers onto the output lanes.
  always_comb begin
    bus.wave_out  = '0;
    bus.ch_active = '0;
    bus.seg_done  = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      bus.wave_out[c*DATA_WIDTH +: DATA_WIDTH] = wave_q[c];
      bus.ch_active[c] = (st[c] == CH_RUN);
      bus.seg_done[c]  = done_q[c];
    end
  end
endmodule

// File: tb/tb_chaos_dds_array.sv
// Bench for chaos_dds_array: timer pacing, table-driven single-channel
// segments through a scoreboard, a load/final-wrap collision, a 4-channel
// reference model run and a mid-segment reset.
module tb_chaos_dds_array;
  localparam int CH   = 4;
  localparam int PW   = 32;
  localparam int DW   = 8;
  localparam int CTRL = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  chaos_dds_if #(.CH_NUM(CH), .PHASE_WIDTH(PW), .DATA_WIDTH(DW)) bus ();

  chaos_dds_array #(
    .CH_NUM(CH), .PHASE_WIDTH(PW), .PERIOD_NUM_WIDTH(3), .FW_DEV_WIDTH(16),
    .DATA_WIDTH(DW), .FRQ_WORD(32'h4000_0000), .CTRL(CTRL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] wave;
    logic       act;
    logic       done;
  } sb_t;
  sb_t q[$];

  typedef struct {
    logic        mode;
    logic [2:0]  n;
    logic [31:0] y;
    logic [1:0]  wave;
    logic [79:0] ew;  // sample k at [79-8k -: 8], read left to right
    logic [9:0]  ea;  // ch_active after edge t+1+k at bit [9-k]
    logic [9:0]  ed;  // seg_done  after edge t+1+k at bit [9-k]
  } vec_t;
  vec_t vecs[6];

  logic [31:0] m_acc  [CH];
  logic [31:0] m_fw   [CH];
  logic [2:0]  m_left [CH];
  logic        m_mode [CH];
  logic        m_act  [CH];
  logic        m_done [CH];
  logic [1:0]  m_wave [CH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic m, input logic [2:0] n, input logic [31:0] y,
                               input logic [1:0] w, input logic [79:0] ew,
                               input logic [9:0] ea, input logic [9:0] ed);
    vec_t v;
    v.mode = m; v.n = n; v.y = y; v.wave = w; v.ew = ew; v.ea = ea; v.ed = ed;
    return v;
  endfunction

  function automatic logic [7:0] lane(input int ch);
    return bus.wave_out[ch*DW +: DW];
  endfunction

  function automatic logic [7:0] shape(input logic [31:0] a, input logic [1:0] w);
    logic [7:0] ph;
    ph = a[31:24];
    if (w == 2'b01) return ph[7] ? 8'hFF - (ph << 1) : (ph << 1);
    if (w == 2'b10) return ph[7] ? 8'hFF : 8'h00;
    return ph;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    bus.chaotic_valid = '0;
  endtask

  task automatic load(input int ch, input logic m, input logic [2:0] n,
                      input logic [31:0] y, input logic [31:0] z, input logic [1:0] w);
    bus.ch_mode[ch]            = m;
    bus.ch_wave[2*ch +: 2]     = w;
    bus.chaotic_x[ch*PW +: PW] = {n, 29'h0ABC_DEF};
    bus.chaotic_y[ch*PW +: PW] = y;
    bus.chaotic_z[ch*PW +: PW] = z;
    bus.chaotic_valid[ch]      = 1'b1;
  endtask

  task automatic push(input logic [7:0] w, input logic a, input logic d);
    sb_t e;
    e.wave = w; e.act = a; e.done = d;
    q.push_back(e);
  endtask

  task automatic check_sb(input int ch, input string tag);
    sb_t e;
    if (q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = q.pop_front();
    chk({tag, "_wave"}, 32'(lane(ch)), 32'(e.wave));
    chk({tag, "_act"},  32'(bus.ch_active[ch]), 32'(e.act));
    chk({tag, "_done"}, 32'(bus.seg_done[ch]), 32'(e.done));
  endtask

  task automatic run_timer(input int ncyc, output int nhigh, output int first, output int second);
    nhigh = 0; first = -1; second = -1;
    for (int k = 1; k <= ncyc; k++) begin
      if (k > 1) step();
      if (bus.chaotic_ctrl === 1'b1) begin
        nhigh++;
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
    end
  endtask

  task automatic m_load(input int c, input logic m, input logic [2:0] n,
                        input logic [31:0] y, input logic [31:0] z, input logic [1:0] w);
    m_fw[c]   = 32'h4000_0000 + {16'h0, z[31:16]};
    m_left[c] = n;
    m_mode[c] = m;
    m_wave[c] = w;
    m_done[c] = 1'b0;
    m_act[c]  = !(m && n == 3'd0);
    m_acc[c]  = m_act[c] ? y : 32'h0;
  endtask

  task automatic m_edge(input int c, output logic [7:0] ew);
    logic [32:0] s;
    ew = m_act[c] ? shape(m_acc[c], m_wave[c]) : 8'h80;
    m_done[c] = 1'b0;
    if (m_act[c]) begin
      s = 33'(m_acc[c]) + 33'(m_fw[c]);
      m_acc[c] = s[31:0];
      if (m_mode[c] && s[32]) begin
        if (m_left[c] == 3'd1) begin
          m_act[c] = 1'b0; m_acc[c] = 32'h0; m_done[c] = 1'b1;
        end else begin
          m_left[c] = m_left[c] - 3'd1;
        end
      end
    end
  endtask

  initial begin
    int nh, f1, f2;
    logic [7:0] ew [CH];

    vecs[0] = mkv(1'b0, 3'd0, 32'h0, 2'b00, 80'h00_40_80_C0_00_40_80_C0_00_40, 10'b1111111111, 10'b0);
    vecs[1] = mkv(1'b0, 3'd0, 32'h0, 2'b01, 80'h00_80_FF_7F_00_80_FF_7F_00_80, 10'b1111111111, 10'b0);
    vecs[2] = mkv(1'b0, 3'd0, 32'h0, 2'b10, 80'h00_00_FF_FF_00_00_FF_FF_00_00, 10'b1111111111, 10'b0);
    vecs[3] = mkv(1'b1, 3'd2, 32'h0, 2'b00, 80'h00_40_80_C0_00_40_80_C0_80_80, 10'b1111111000, 10'b0000000100);
    vecs[4] = mkv(1'b1, 3'd0, 32'h0, 2'b00, 80'h80_80_80_80_80_80_80_80_80_80, 10'b0000000000, 10'b0);
    vecs[5] = mkv(1'b1, 3'd1, 32'h4000_0000, 2'b01, 80'h80_FF_7F_80_80_80_80_80_80_80, 10'b1100000000, 10'b0010000000);

    bus.ch_mode = '0; bus.ch_wave = '0; bus.chaotic_valid = '0;
    bus.chaotic_x = '0; bus.chaotic_y = '0; bus.chaotic_z = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wave", bus.wave_out, 32'h8080_8080);
    chk("rst_act",  32'(bus.ch_active), 32'h0);
    chk("rst_done", 32'(bus.seg_done), 32'h0);
    chk("rst_ctrl", 32'(bus.chaotic_ctrl), 32'h0);

    rst = 1'b0;
    run_timer(2005, nh, f1, f2);
    chk("tmr_count",  32'(nh), 32'd2);
    chk("tmr_first",  32'(f1), 32'd1000);
    chk("tmr_second", 32'(f2), 32'd2000);

    for (int i = 0; i < 6; i++) begin
      load(0, vecs[i].mode, vecs[i].n, vecs[i].y, 32'h0, vecs[i].wave);
      step();
      for (int k = 0; k < 10; k++)
        push(vecs[i].ew[79-8*k -: 8], vecs[i].ea[9-k], vecs[i].ed[9-k]);
      for (int k = 0; k < 10; k++) begin
        step();
        check_sb(0, $sformatf("vec%0d_s%0d", i, k));
      end
    end

    load(1, 1'b1, 3'd2, 32'h0, 32'h0, 2'b00);
    step();
    push(8'h00, 1'b1, 1'b0); push(8'h40, 1'b1, 1'b0); push(8'h80, 1'b1, 1'b0);
    push(8'hC0, 1'b1, 1'b0); push(8'h00, 1'b1, 1'b0); push(8'h40, 1'b1, 1'b0);
    push(8'h80, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) begin
      step();
      check_sb(1, $sformatf("coll_a%0d", k));
    end
    load(1, 1'b1, 3'd2, 32'h8000_0000, 32'h0, 2'b00);
    push(8'hC0, 1'b1, 1'b0); push(8'h80, 1'b1, 1'b0); push(8'hC0, 1'b1, 1'b0);
    push(8'h00, 1'b1, 1'b0); push(8'h40, 1'b1, 1'b0); push(8'h80, 1'b1, 1'b0);
    push(8'hC0, 1'b0, 1'b1); push(8'h80, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step();
      check_sb(1, $sformatf("coll_b%0d", k));
    end

    load(0, 1'b0, 3'd5, 32'h1000_0000, 32'h1234_0000, 2'b00); m_load(0, 1'b0, 3'd5, 32'h1000_0000, 32'h1234_0000, 2'b00);
    load(1, 1'b1, 3'd3, 32'h2000_0000, 32'h0,         2'b01); m_load(1, 1'b1, 3'd3, 32'h2000_0000, 32'h0,         2'b01);
    load(2, 1'b0, 3'd0, 32'hF000_0000, 32'hFFFF_0000, 2'b10); m_load(2, 1'b0, 3'd0, 32'hF000_0000, 32'hFFFF_0000, 2'b10);
    load(3, 1'b1, 3'd1, 32'h0,         32'h8000_0000, 2'b11); m_load(3, 1'b1, 3'd1, 32'h0,         32'h8000_0000, 2'b11);
    step();
    for (int k = 0; k < 30; k++) begin
      if (k == 5) bus.ch_mode = ~bus.ch_mode;
      for (int c = 0; c < CH; c++) m_edge(c, ew[c]);
      step();
      for (int c = 0; c < CH; c++) begin
        chk($sformatf("ind_c%0d_k%0d_wave", c, k), 32'(lane(c)), 32'(ew[c]));
        chk($sformatf("ind_c%0d_k%0d_act", c, k), 32'(bus.ch_active[c]), 32'(m_act[c]));
        chk($sformatf("ind_c%0d_k%0d_done", c, k), 32'(bus.seg_done[c]), 32'(m_done[c]));
      end
    end

    load(1, 1'b1, 3'd4, 32'h0, 32'h0, 2'b00);
    step();
    step();
    rst = 1'b1;
    step();
    chk("mid_rst_wave", bus.wave_out, 32'h8080_8080);
    chk("mid_rst_act",  32'(bus.ch_active), 32'h0);
    chk("mid_rst_done", 32'(bus.seg_done), 32'h0);
    chk("mid_rst_ctrl", 32'(bus.chaotic_ctrl), 32'h0);
    rst = 1'b0;
    run_timer(1001, nh, f1, f2);
    chk("tmr2_count", 32'(nh), 32'd1);
    chk("tmr2_first", 32'(f1), 32'd1000);
    chk("post_rst_act", 32'(bus.ch_active), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
